spi_flash_rd: RTL
=================

# spi_flash_rd

Wishbone-master sequencer that drives the `wb_spi` SPI master to perform SPI-flash READ (0x03) transactions: it configures the clock divisor, asserts chip select, shifts out command and 24-bit address, then clocks in a requested number of data bytes and streams them out over a valid/ready byte port. It sits between a boot/loader client and the `wb_spi` slave on the peripheral bus, making `wb_spi` the only agent moving bytes on the flash pins.

## Interface
- `BASE_ADR`, 32'h0000_0000: base address of the `wb_spi` register window. Offsets: +0x00 data, +0x04 status (bit0 = run), +0x08 cs, +0x0C divisor.
- `DIVISOR`, 32'd4: value written to `wb_spi` divisor at every transaction start.
- `CS_SEL`, 8'hFE: value written to cs to select the flash. 8'hFF deselects.
- `CMD`, 8'h03: command byte.
- `TMO`, 8'd255: maximum cycles to wait for `m_ack_i` per access.
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_i` in 1: start request, sampled only in IDLE.
- `req_addr_i` in 24: flash byte address.
- `req_len_i` in 16: number of data bytes, 0..65535.
- `abort_i` in 1: terminate current transaction early.
- `busy_o` out 1: transaction in progress.
- `done_o` out 1: one-cycle end-of-transaction pulse.
- `err_o` out 1: sticky ack-timeout flag, cleared on next accepted request.
- `rd_data_o` out 8: received byte.
- `rd_valid_o` out 1: `rd_data_o` valid, held until `rd_ready_i`.
- `rd_ready_i` in 1: consumer accepts byte.
- `m_adr_o` out 32, `m_dat_o` out 32, `m_sel_o` out 4 (always 4'hF), `m_we_o` out 1, `m_cyc_o` out 1, `m_stb_o` out 1: Wishbone master outputs.
- `m_dat_i` in 32, `m_ack_i` in 1: Wishbone master inputs.

## Operation
- States: IDLE, CFG (write divisor), CSON (write `CS_SEL`), TX (write data reg), POLL (read status), RX (read data reg), OUT (present byte), CSOFF (write 8'hFF), DONE.
- IDLE, `req_i`=1, len≠0: latch addr/len, clear `err_o`, go CFG.
- IDLE, `req_i`=1, len=0: clear `err_o`, go to DONE with no bus traffic.
- Byte sequence: index 0 = `CMD`, 1..3 = addr[23:16], [15:8], [7:0]. Indices 4..len+3 send 8'h00.
- Each byte runs TX → POLL (repeat until `m_dat_i[0]`=0) → RX.
- For indices 0..3, the RX read result is discarded and the sequencer continues to the next TX.
- For data bytes, RX captures `m_dat_i[7:0]` into `rd_data_o` and enters OUT. OUT holds `rd_valid_o`=1 until `rd_ready_i`=1, then continues to the next TX, or to CSOFF after the last byte.
- Byte counter is 17 bits wide. No wrap: len 65535 yields exactly 65535 data bytes. Flash address is not incremented by this block.
- CSOFF → DONE → IDLE.
- `abort_i` is sampled every cycle while busy and sets a pending flag.
  - Any in-flight bus access completes first.
  - Then go to CSOFF; from OUT, go immediately without emitting the byte.
  - `abort_i` in IDLE is ignored.
- Timeout: a counter runs while `m_stb_o`=1. If it reaches `TMO` without `m_ack_i`, drop cyc/stb, set `err_o`=1, go DONE. No CSOFF is attempted.
- Reset (any state): immediate return to IDLE, all outputs to reset values. The `wb_spi` cs state is not restored.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `err_o`=0, `rd_valid_o`=0, `rd_data_o`=0, `m_cyc_o`=0, `m_stb_o`=0, `m_we_o`=0, `m_adr_o`=0, `m_dat_o`=0.
- `busy_o` rises the cycle after `req_i` is accepted and falls in the same cycle `done_o` pulses.
- A new `req_i` is accepted no earlier than the cycle after `done_o`.
- Bus access:
  - `m_cyc_o`, `m_stb_o`, `m_adr_o`, `m_we_o` and `m_dat_o` are registered and held constant until `m_ack_i`=1.
  - cyc/stb deassert in the cycle following ack.
  - Then at least 2 cycles with stb low before the next access. This is required because the `wb_spi` ack is registered from stb&cyc.
- `wb_spi` acks 1 cycle after stb. Best-case cost per access is therefore 4 cycles: stb, ack, 2 gap.
- A len=N transaction performs 3 + 3·(N+4) + P accesses, where P is the number of extra status polls.
- `done_o` is asserted 1 cycle after the CSOFF ack gap. For len=0, it is asserted 1 cycle after acceptance.
- `rd_valid_o` rises 1 cycle after the RX ack. It falls in the cycle after `rd_valid_o`&&`rd_ready_i`.
- If `abort_i` and `rd_ready_i` are both asserted in OUT, the byte is consumed and then CSOFF follows.

## Test plan
- Read 4 bytes at addr 0x012345 against a `wb_spi` plus flash model returning 0xA0..0xA3, `rd_ready_i`=1:
  - writes: divisor=4, cs=0xFE, data 0x03,0x01,0x23,0x45,0x00×4, cs=0xFF;
  - 4 valid bytes 0xA0..0xA3;
  - one `done_o` pulse; `err_o`=0.
- Same read with `rd_ready_i` low for 10 cycles per byte:
  - `rd_valid_o`/`rd_data_o` stable while stalled;
  - no TX issued while in OUT;
  - exactly 4 handshakes.
- `req_len_i`=0: no `m_cyc_o` activity; `done_o` one cycle after acceptance.
- `abort_i` pulsed during the 2nd data byte of a len=8 read:
  - at most 2 bytes delivered;
  - last write is cs=0xFF;
  - `done_o` pulses and `busy_o`=0.
- Slave never acks:
  - cyc/stb drop after 255 cycles;
  - `err_o`=1 and `done_o` pulses;
  - the next `req_i` clears `err_o`.
- Assert `reset`=0 mid-POLL: all outputs at reset values in the same cycle; after release, a new len=1 read completes correctly.

Source files
------------

// File: rtl/spi_flash_rd_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_flash_rd_if
// Purpose : Wishbone master bus bundle between spi_flash_rd and wb_spi.
// Rev     : 1.0
// ============================================================================
interface spi_flash_rd_if;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_we_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  modport master (
    output m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o,
    output m_dat_i, m_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/spi_flash_rd.sv
`default_nettype none
// ============================================================================
// Module  : spi_flash_rd
// Purpose : Sequences wb_spi register accesses to run SPI-flash READ (0x03).
// Rev     : 1.0
// ============================================================================
module spi_flash_rd #(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter logic [31:0] DIVISOR  = 32'd4,
  parameter logic [7:0]  CS_SEL   = 8'hFE,
  parameter logic [7:0]  CMD      = 8'h03,
  parameter logic [7:0]  TMO      = 8'd255
) (
  input  wire          clk,
  input  wire          reset,
  input  wire          req_i,
  input  wire  [23:0]  req_addr_i,
  input  wire  [15:0]  req_len_i,
  input  wire          abort_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [7:0]   rd_data_o,
  output logic         rd_valid_o,
  input  wire          rd_ready_i,
  spi_flash_rd_if.master m
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_CSON, S_TX, S_POLL, S_RX, S_OUT, S_CSOFF, S_DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = TMO - 8'd1;

  state_t      state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [16:0] idx_q, idx_d;
  logic [1:0]  gap_q, gap_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        abort_q, abort_d, fin_q, fin_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;

  logic        ack, abort_any, gap_ok;
  logic [16:0] total;
  logic [7:0]  tx_byte;
  logic [31:0] acc_adr, acc_dat;
  logic        acc_we;
  logic        unused_dat;

  assign ack        = stb_q & m.m_ack_i;
  assign abort_any  = abort_q | abort_i;
  assign gap_ok     = (gap_q != 2'd2);
  assign total      = {1'b0, len_q} + 17'd4;
  assign unused_dat = ^m.m_dat_i[31:8];

  // Register access that the current state performs when it launches.
  always_comb begin
    case (idx_q)
      17'd0:   tx_byte = CMD;
      17'd1:   tx_byte = addr_q[23:16];
      17'd2:   tx_byte = addr_q[15:8];
      17'd3:   tx_byte = addr_q[7:0];
      default: tx_byte = 8'h00;
    endcase
    acc_adr = BASE_ADR;
    acc_we  = 1'b0;
    acc_dat = 32'h0;
    case (state_q)
      S_CFG:   begin acc_adr = BASE_ADR + 32'hC; acc_we = 1'b1; acc_dat = DIVISOR; end
      S_CSON:  begin acc_adr = BASE_ADR + 32'h8; acc_we = 1'b1; acc_dat = {24'h0, CS_SEL}; end
      S_TX:    begin acc_we = 1'b1; acc_dat = {24'h0, tx_byte}; end
      S_POLL:  acc_adr = BASE_ADR + 32'h4;
      S_CSOFF: begin acc_adr = BASE_ADR + 32'h8; acc_we = 1'b1; acc_dat = 32'hFF; end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    abort_d    = abort_q | (busy_q & abort_i);
    fin_d      = fin_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    // wb_spi registers its ack from stb&cyc, so two idle cycles follow every ack.
    if (ack)                gap_d = 2'd2;
    else if (gap_q != 2'd0) gap_d = gap_q - 2'd1;
    else                    gap_d = gap_q;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          err_d   = 1'b0;
          abort_d = 1'b0;
          if (req_len_i == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            addr_d  = req_addr_i;
            len_d   = req_len_i;
            idx_d   = 17'd0;
            fin_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_CFG;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      S_OUT: begin
        if (rd_ready_i) begin
          rd_valid_d = 1'b0;
          state_d    = (abort_any || idx_q == total) ? S_CSOFF : S_TX;
        end else if (abort_any) begin
          rd_valid_d = 1'b0;
          state_d    = S_CSOFF;
        end
      end
      default: begin
        if (stb_q) begin
          if (ack) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            case (state_q)
              S_CFG:   state_d = S_CSON;
              S_CSON:  state_d = S_TX;
              S_TX:    state_d = S_POLL;
              S_POLL:  state_d = m.m_dat_i[0] ? S_POLL : S_RX;
              S_RX: begin
                idx_d = idx_q + 17'd1;
                if (idx_q >= 17'd4) begin
                  rd_data_d  = m.m_dat_i[7:0];
                  rd_valid_d = 1'b1;
                  state_d    = S_OUT;
                end else begin
                  state_d = S_TX;
                end
              end
              default: fin_d = 1'b1;
            endcase
            if (abort_any && state_q != S_CSOFF) begin
              rd_valid_d = 1'b0;
              state_d    = S_CSOFF;
            end
          end else if (tmo_q == TMO_LAST) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            abort_d = 1'b0;
            state_d = S_DONE;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end else if (fin_q) begin
          if (gap_q == 2'd1) begin
            fin_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            abort_d = 1'b0;
            state_d = S_DONE;
          end
        end else if (gap_ok) begin
          if (abort_any && state_q != S_CSOFF) begin
            state_d = S_CSOFF;
          end else begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            we_d  = acc_we;
            adr_d = acc_adr;
            dat_d = acc_dat;
            tmo_d = 8'd0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      abort_q    <= 1'b0;
      fin_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      abort_q    <= abort_d;
      fin_q      <= fin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign m.m_cyc_o  = cyc_q;
  assign m.m_stb_o  = stb_q;
  assign m.m_we_o   = we_q;
  assign m.m_adr_o  = adr_q;
  assign m.m_dat_o  = dat_q;
  assign m.m_sel_o  = 4'hF;

endmodule
`default_nettype wire
